// File: rtl/uarch_pkg.sv
// Shared micro-architecture types: CPU widths, the instruction packet
// and the data-memory controller state encoding.
package uarch_pkg;

    localparam int CPU_ADDR_BITS = 32;
    localparam int CPU_DATA_BITS = 32;

    typedef struct packed {
        logic [15:0] pc;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [7:0]  rob_id;
    } instruction_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        LDATA = 2'd2,
        RESP  = 2'd3
    } dmem_state_e;

endpackage

// File: rtl/dmem_ctrl.sv
// Single-port data-memory controller: arbitrates LSQ loads and committed-store
// drains onto one dcache port and returns load words over a valid/ready handshake.
module dmem_ctrl
    import uarch_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     ld_req_val,
    output logic                     ld_req_rdy,
    input  logic [CPU_ADDR_BITS-1:0] ld_req_addr,
    input  instruction_t             ld_req_pkt,
    input  logic                     st_req_val,
    output logic                     st_req_rdy,
    input  logic [CPU_ADDR_BITS-1:0] st_req_addr,
    input  logic [CPU_DATA_BITS-1:0] st_req_data,
    input  logic [3:0]               st_req_be,
    output logic                     st_done,
    output logic [CPU_ADDR_BITS-1:0] dcache_addr,
    output logic                     dcache_re,
    output logic [CPU_DATA_BITS-1:0] dcache_din,
    output logic [3:0]               dcache_we,
    input  logic                     dcache_stall,
    input  logic [CPU_DATA_BITS-1:0] dcache_dout,
    output logic                     dmem_valid,
    input  logic                     dmem_rdy,
    output instruction_t             dmem_packet,
    output logic [CPU_DATA_BITS-1:0] dmem_rdata
);

    dmem_state_e              state_q, state_d;
    logic [CPU_ADDR_BITS-1:0] addr_q, addr_d;
    logic [CPU_DATA_BITS-1:0] data_q, data_d;
    logic [3:0]               be_q, be_d;
    instruction_t             pkt_q, pkt_d;
    logic [CPU_DATA_BITS-1:0] rdata_q, rdata_d;
    logic                     is_ld_q, is_ld_d;
    logic                     killed_q, killed_d;
    logic                     last_st_q, last_st_d;

    logic ld_eligible;
    logic grant_st;
    logic grant_ld;

    // A flushed load never competes; a waiting store wins unless it went last.
    assign ld_eligible = ld_req_val && !flush;
    assign grant_st    = (state_q == IDLE) && st_req_val && (!ld_eligible || !last_st_q);
    assign grant_ld    = (state_q == IDLE) && ld_eligible && !grant_st;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        be_d       = be_q;
        pkt_d      = pkt_q;
        rdata_d    = rdata_q;
        is_ld_d    = is_ld_q;
        killed_d   = killed_q;
        last_st_d  = last_st_q;
        ld_req_rdy = 1'b0;
        st_req_rdy = 1'b0;
        st_done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_st) begin
                    st_req_rdy = 1'b1;
                    addr_d     = st_req_addr;
                    data_d     = st_req_data;
                    be_d       = st_req_be;
                    is_ld_d    = 1'b0;
                    killed_d   = 1'b0;
                    last_st_d  = 1'b1;
                    state_d    = REQ;
                end else if (grant_ld) begin
                    ld_req_rdy = 1'b1;
                    addr_d     = ld_req_addr;
                    data_d     = '0;
                    be_d       = '0;
                    pkt_d      = ld_req_pkt;
                    is_ld_d    = 1'b1;
                    killed_d   = 1'b0;
                    last_st_d  = 1'b0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                // The cache access cannot be aborted, so a flush only marks the load.
                if (flush) begin
                    killed_d = 1'b1;
                end
                if (!dcache_stall) begin
                    if (is_ld_q) begin
                        state_d = LDATA;
                    end else begin
                        st_done = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            LDATA: begin
                rdata_d = dcache_dout;
                if (flush) begin
                    killed_d = 1'b1;
                end
                state_d = (killed_q || flush) ? IDLE : RESP;
            end
            RESP: begin
                if (dmem_rdy || flush) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            be_q      <= '0;
            pkt_q     <= '0;
            rdata_q   <= '0;
            is_ld_q   <= 1'b0;
            killed_q  <= 1'b0;
            last_st_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            be_q      <= be_d;
            pkt_q     <= pkt_d;
            rdata_q   <= rdata_d;
            is_ld_q   <= is_ld_d;
            killed_q  <= killed_d;
            last_st_q <= last_st_d;
        end
    end

    // Cache port is decoded from state and held registers only, so it stays put across stalls.
    assign dcache_re   = (state_q == REQ) && is_ld_q;
    assign dcache_we   = (state_q == REQ && !is_ld_q) ? be_q : 4'b0000;
    assign dcache_addr = (state_q == REQ) ? addr_q : '0;
    assign dcache_din  = (state_q == REQ && !is_ld_q) ? data_q : '0;
    assign dmem_valid  = (state_q == RESP);
    assign dmem_packet = pkt_q;
    assign dmem_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level model and a backing memory.
module tb_dmem_ctrl;
    import uarch_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic                     ld_req_val;
    logic                     ld_req_rdy;
    logic [CPU_ADDR_BITS-1:0] ld_req_addr;
    instruction_t             ld_req_pkt;
    logic                     st_req_val;
    logic                     st_req_rdy;
    logic [CPU_ADDR_BITS-1:0] st_req_addr;
    logic [CPU_DATA_BITS-1:0] st_req_data;
    logic [3:0]               st_req_be;
    logic                     st_done;
    logic [CPU_ADDR_BITS-1:0] dcache_addr;
    logic                     dcache_re;
    logic [CPU_DATA_BITS-1:0] dcache_din;
    logic [3:0]               dcache_we;
    logic                     dcache_stall;
    logic [CPU_DATA_BITS-1:0] dcache_dout;
    logic                     dmem_valid;
    logic                     dmem_rdy;
    instruction_t             dmem_packet;
    logic [CPU_DATA_BITS-1:0] dmem_rdata;

    dmem_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .ld_req_val   (ld_req_val),
        .ld_req_rdy   (ld_req_rdy),
        .ld_req_addr  (ld_req_addr),
        .ld_req_pkt   (ld_req_pkt),
        .st_req_val   (st_req_val),
        .st_req_rdy   (st_req_rdy),
        .st_req_addr  (st_req_addr),
        .st_req_data  (st_req_data),
        .st_req_be    (st_req_be),
        .st_done      (st_done),
        .dcache_addr  (dcache_addr),
        .dcache_re    (dcache_re),
        .dcache_din   (dcache_din),
        .dcache_we    (dcache_we),
        .dcache_stall (dcache_stall),
        .dcache_dout  (dcache_dout),
        .dmem_valid   (dmem_valid),
        .dmem_rdy     (dmem_rdy),
        .dmem_packet  (dmem_packet),
        .dmem_rdata   (dmem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 64) return 32'hDEADBEEF;
        return (i * 32'h01000193) ^ 32'h5A5A5A5A;
    endfunction

    // Transaction model: one outstanding transaction, tracked by what has happened to it.
    localparam int PH_IDLE   = 0;
    localparam int PH_ACCESS = 1;
    localparam int PH_RETURN = 2;
    localparam int PH_HOLD   = 3;

    int           m_phase;
    bit           m_is_ld;
    bit           m_killed;
    bit           m_last_st;
    logic [31:0]  m_addr;
    logic [31:0]  m_data;
    logic [3:0]   m_be;
    instruction_t m_pkt;
    logic [31:0]  m_result;
    logic [31:0]  m_mem [256];
    logic [31:0]  c_mem [256];

    function automatic bit exp_st_grant();
        return (m_phase == PH_IDLE) && st_req_val && !(ld_req_val && !flush && m_last_st);
    endfunction

    function automatic bit exp_ld_grant();
        return (m_phase == PH_IDLE) && ld_req_val && !flush && !exp_st_grant();
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase   <= PH_IDLE;
            m_last_st <= 1'b0;
            m_killed  <= 1'b0;
            for (int i = 0; i < 256; i++) m_mem[i] <= init_word(i);
        end else begin
            case (m_phase)
                PH_IDLE: begin
                    if (exp_st_grant()) begin
                        m_phase <= PH_ACCESS; m_is_ld <= 1'b0; m_killed <= 1'b0; m_last_st <= 1'b1;
                        m_addr <= st_req_addr; m_data <= st_req_data; m_be <= st_req_be;
                    end else if (exp_ld_grant()) begin
                        m_phase <= PH_ACCESS; m_is_ld <= 1'b1; m_killed <= 1'b0; m_last_st <= 1'b0;
                        m_addr <= ld_req_addr; m_pkt <= ld_req_pkt;
                    end
                end
                PH_ACCESS: begin
                    if (flush) m_killed <= 1'b1;
                    if (!dcache_stall) begin
                        if (m_is_ld) begin
                            m_result <= m_mem[m_addr[9:2]];
                            m_phase  <= PH_RETURN;
                        end else begin
                            for (int b = 0; b < 4; b++)
                                if (m_be[b]) m_mem[m_addr[9:2]][b*8 +: 8] <= m_data[b*8 +: 8];
                            m_phase <= PH_IDLE;
                        end
                    end
                end
                PH_RETURN: m_phase <= (m_killed || flush) ? PH_IDLE : PH_HOLD;
                default:   if (dmem_rdy || flush) m_phase <= PH_IDLE;
            endcase
        end
    end

    // Behavioural cache: read data one cycle after an unstalled read, byte-enabled writes.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dcache_dout <= '0;
            for (int i = 0; i < 256; i++) c_mem[i] <= init_word(i);
        end else if (!dcache_stall) begin
            if (dcache_re) dcache_dout <= c_mem[dcache_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (dcache_we[b]) c_mem[dcache_addr[9:2]][b*8 +: 8] <= dcache_din[b*8 +: 8];
        end
    end

    bit glog [$];
    int n_st_done = 0;

    always @(negedge clk) begin
        if (!rst) begin
            bit acc, st;
            if (st_req_rdy) glog.push_back(1'b1);
            if (ld_req_rdy) glog.push_back(1'b0);
            if (st_done) n_st_done++;
            acc = (m_phase == PH_ACCESS);
            st  = acc && !m_is_ld;
            chk("ld_req_rdy", ld_req_rdy, exp_ld_grant());
            chk("st_req_rdy", st_req_rdy, exp_st_grant());
            chk("dcache_re", dcache_re, acc && m_is_ld);
            chk("dcache_we", dcache_we, st ? m_be : 4'b0000);
            chk("dcache_addr", dcache_addr, acc ? m_addr : 32'h0);
            chk("dcache_din", dcache_din, st ? m_data : 32'h0);
            chk("st_done", st_done, st && !dcache_stall);
            chk("dmem_valid", dmem_valid, m_phase == PH_HOLD);
            if (m_phase == PH_HOLD) begin
                chk("dmem_rdata", dmem_rdata, m_result);
                chk("dmem_packet", dmem_packet, m_pkt);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        ld_req_val = 0; st_req_val = 0; flush = 0; dcache_stall = 0; dmem_rdy = 1;
    endtask

    initial begin
        instruction_t p1, p2;
        int g0, d0, guard;
        p1 = '{pc: 16'h1234, rd: 5'd7, funct3: 3'd2, rob_id: 8'h5A};
        p2 = '{pc: 16'hBEEF, rd: 5'd3, funct3: 3'd0, rob_id: 8'hC3};
        quiet();
        ld_req_addr = 0; ld_req_pkt = '0; st_req_addr = 0; st_req_data = 0; st_req_be = 4'hF;
        rst = 1;
        #2;
        chk("rst_valid", dmem_valid, 0);
        chk("rst_re", dcache_re, 0);
        chk("rst_we", dcache_we, 0);
        chk("rst_rdata", dmem_rdata, 0);
        step();
        rst = 0;
        step();

        // Load-only latency.
        ld_req_val = 1; ld_req_addr = 32'h100; ld_req_pkt = p1;
        #1 chk("t1_grant", ld_req_rdy, 1);
        step(); ld_req_val = 0;
        #1 chk("t1_re_T1", dcache_re, 1);
        chk("t1_addr_T1", dcache_addr, 32'h100);
        step();
        #1 chk("t1_valid_T2", dmem_valid, 0);
        step();
        #1 chk("t1_valid_T3", dmem_valid, 1);
        chk("t1_rdata", dmem_rdata, 32'hDEADBEEF);
        chk("t1_packet", dmem_packet, p1);
        repeat (2) step();

        // Back-to-back conflicts after reset alternate store, load, store, load.
        rst = 1; #2; rst = 0;
        step();
        g0 = glog.size(); d0 = n_st_done;
        ld_req_val = 1; ld_req_addr = 32'h44; ld_req_pkt = p2;
        st_req_val = 1; st_req_addr = 32'h40; st_req_data = 32'h11223344; st_req_be = 4'hF;
        guard = 0;
        while (glog.size() < g0 + 4 && guard < 60) begin
            step();
            guard++;
        end
        ld_req_val = 0; st_req_val = 0;
        chk("t2_grant_budget", guard < 60, 1);
        if (glog.size() >= g0 + 4) begin
            chk("t2_grant0", glog[g0], 1);
            chk("t2_grant1", glog[g0+1], 0);
            chk("t2_grant2", glog[g0+2], 1);
            chk("t2_grant3", glog[g0+3], 0);
        end
        repeat (8) step();
        chk("t2_st_done_count", n_st_done - d0, 2);

        // Store held over a 3-cycle stall.
        st_req_val = 1; st_req_addr = 32'h80; st_req_data = 32'hA5A51234; st_req_be = 4'b0110;
        #1 chk("t3_grant", st_req_rdy, 1);
        step(); st_req_val = 0; dcache_stall = 1;
        #1 chk("t3_we_0", dcache_we, 4'b0110);
        chk("t3_done_0", st_done, 0);
        for (int i = 1; i < 4; i++) begin
            step();
            if (i == 3) dcache_stall = 0;
            #1 chk("t3_addr_hold", dcache_addr, 32'h80);
            chk("t3_din_hold", dcache_din, 32'hA5A51234);
            chk("t3_we_hold", dcache_we, 4'b0110);
            chk("t3_done", st_done, i == 3);
        end
        step();
        #1 chk("t3_done_after", st_done, 0);
        chk("t3_we_after", dcache_we, 0);
        repeat (2) step();

        // Flush a stalled load: access completes, result is dropped.
        ld_req_val = 1; ld_req_addr = 32'h100; ld_req_pkt = p1;
        #1 chk("t4_grant", ld_req_rdy, 1);
        step(); ld_req_val = 0; dcache_stall = 1; flush = 1;
        step(); flush = 0;
        step(); dcache_stall = 0;
        #1 chk("t4_re_unstalled", dcache_re, 1);
        step(); ld_req_val = 1; ld_req_addr = 32'h104; ld_req_pkt = p2;
        #1 chk("t4_busy_ldata", ld_req_rdy, 0);
        chk("t4_no_valid", dmem_valid, 0);
        step();
        #1 chk("t4_idle_again", ld_req_rdy, 1);
        chk("t4_no_valid2", dmem_valid, 0);
        step(); ld_req_val = 0;
        repeat (6) step();

        // Consumer back-pressure in the response phase.
        dmem_rdy = 0;
        ld_req_val = 1; ld_req_addr = 32'h104; ld_req_pkt = p2;
        #1 chk("t5_grant", ld_req_rdy, 1);
        step(); ld_req_addr = 32'h108;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            #1 chk("t5_valid_hold", dmem_valid, 1);
            chk("t5_rdata_hold", dmem_rdata, init_word(65));
            chk("t5_pkt_hold", dmem_packet, p2);
            chk("t5_no_grant", ld_req_rdy, 0);
            step();
        end
        dmem_rdy = 1;
        #1 chk("t5_valid_last", dmem_valid, 1);
        step();
        #1 chk("t5_grant_after", ld_req_rdy, 1);
        chk("t5_valid_drop", dmem_valid, 0);
        step(); ld_req_val = 0;
        repeat (6) step();

        // Asynchronous reset in the load-data cycle.
        ld_req_val = 1; ld_req_addr = 32'h10; ld_req_pkt = p1;
        #1 chk("t6_grant", ld_req_rdy, 1);
        step(); ld_req_val = 0;
        step();
        rst = 1;
        #1 chk("t6_re", dcache_re, 0);
        chk("t6_we", dcache_we, 0);
        chk("t6_addr", dcache_addr, 0);
        chk("t6_din", dcache_din, 0);
        chk("t6_valid", dmem_valid, 0);
        chk("t6_rdata", dmem_rdata, 0);
        chk("t6_packet", dmem_packet, 0);
        chk("t6_st_done", st_done, 0);
        step(); rst = 0;
        ld_req_val = 1; st_req_val = 1; st_req_addr = 32'h20; st_req_data = 32'h0BADF00D; st_req_be = 4'hF;
        #1 chk("t6_first_conflict_st", st_req_rdy, 1);
        chk("t6_first_conflict_ld", ld_req_rdy, 0);
        step(); ld_req_val = 0; st_req_val = 0;
        repeat (4) step();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            step();
            ld_req_val   = ($urandom_range(0, 2) != 0);
            st_req_val   = ($urandom_range(0, 2) == 0);
            flush        = ($urandom_range(0, 9) == 0);
            dcache_stall = ($urandom_range(0, 3) == 0);
            dmem_rdy     = ($urandom_range(0, 9) < 7);
            ld_req_addr  = $urandom_range(0, 31) * 4;
            ld_req_pkt   = instruction_t'($urandom);
            st_req_addr  = $urandom_range(0, 31) * 4;
            st_req_data  = $urandom;
            st_req_be    = 4'($urandom_range(1, 15));
        end
        quiet();
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
